uart_rx_deserializer: RTL and testbench

Downstream consumer of the baud tick generator inside the UART receiver. It oversamples the asynchronous serial line on each tick, finds the start bit and verifies it at mid-bit, then shifts in DATA_BITS data bits LSB-first and checks the stop bit. A good byte is presented on a valid/ready holding register to the receiver's byte sink. The parent top instantiates the tick generator beside this block, with its count set so that tick rate = OVERSAMPLE × baud.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_rx_sync.sv | 22 ++
 rtl/uart_rx_deserializer.sv | 158 +++++++++++++++
 tb/tb_uart_rx_deserializer.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and default frame geometry.
package uart_pkg;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_OVERSAMPLE = 16;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle (high) level.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: non-blocking assignments let both flops sample their old values on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_deserializer.sv
// Oversampling UART receive deserializer: start detect, mid-bit sampling, stop check,
// and a valid/ready holding register toward the byte sink.
module uart_rx_deserializer
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = UART_DATA_BITS,
  parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_frame_err,
  output logic                 rx_overrun,
  output logic                 rx_busy
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2(DATA_BITS + 1);

  localparam logic [TICK_W-1:0] MID_TICK  = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_BITS - 1);

  logic rx_s;

  rx_state_t              state_q, state_d;
  logic [TICK_W-1:0]      tick_cnt_q, tick_cnt_d;
  logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic                   armed_q, armed_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   frame_err_q, frame_err_d;
  logic                   overrun_q, overrun_d;

  uart_rx_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      tick_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      armed_q     <= 1'b1;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      armed_q     <= armed_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  // NOTE: every variable gets a default first so no path can leave one unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    armed_d     = armed_q;
    data_d      = data_q;
    valid_d     = valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    // An accept empties the holding register unless a stop-sample load below refills it.
    if (valid_q && rx_ready) begin
      valid_d = 1'b0;
    end

    if (baud_tick) begin
      case (state_q)
        IDLE: begin
          if (rx_s) begin
            armed_d = 1'b1;
          end else if (armed_q) begin
            state_d    = START;
            tick_cnt_d = '0;
          end
        end

        START: begin
          if (tick_cnt_q == MID_TICK) begin
            tick_cnt_d = '0;
            if (!rx_s) begin
              state_d   = DATA;
              bit_cnt_d = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TICK_W'(1);
          end
        end

        DATA: begin
          if (tick_cnt_q == LAST_TICK) begin
            shreg_d    = {rx_s, shreg_q[DATA_BITS-1:1]};
            tick_cnt_d = '0;
            bit_cnt_d  = bit_cnt_q + BIT_W'(1);
            if (bit_cnt_q == LAST_BIT) begin
              state_d = STOP;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TICK_W'(1);
          end
        end

        STOP: begin
          if (tick_cnt_q == LAST_TICK) begin
            state_d    = IDLE;
            tick_cnt_d = '0;
            if (rx_s) begin
              if (!valid_q || rx_ready) begin
                data_d  = shreg_q;
                valid_d = 1'b1;
              end else begin
                overrun_d = 1'b1;
              end
            end else begin
              // A break must be seen high again before a new start is accepted.
              frame_err_d = 1'b1;
              armed_d     = 1'b0;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TICK_W'(1);
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  assign rx_data      = data_q;
  assign rx_valid     = valid_q;
  assign rx_frame_err = frame_err_q;
  assign rx_overrun   = overrun_q;
  assign rx_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Self-checking bench: directed frames plus randomized traffic compared every cycle
// against a tick-age based behavioural receiver model.
module tb_uart_rx_deserializer;

  localparam int DB          = uart_pkg::UART_DATA_BITS;
  localparam int OS          = uart_pkg::UART_OVERSAMPLE;
  localparam int CLK_PER_BIT = 64;
  // Ticks from start detection to the stop-bit sample: half a bit, DB data bits, one stop bit.
  localparam int STOP_AGE    = OS / 2 + OS * (DB + 1);

  logic          clk       = 1'b0;
  logic          rst       = 1'b1;
  logic          baud_tick = 1'b0;
  logic          rx        = 1'b1;
  logic          rx_ready  = 1'b0;
  logic [DB-1:0] rx_data;
  logic          rx_valid;
  logic          rx_frame_err;
  logic          rx_overrun;
  logic          rx_busy;

  int total = 0;
  int bad   = 0;

  int ready_mode  = 0;  // 0: fixed level, 1: random, 2: pulse on the stop-sample edge only
  logic ready_fixed = 1'b0;

  always #5 clk = ~clk;

  uart_rx_deserializer #(
    .DATA_BITS  (DB),
    .OVERSAMPLE (OS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .baud_tick    (baud_tick),
    .rx           (rx),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .rx_frame_err (rx_frame_err),
    .rx_overrun   (rx_overrun),
    .rx_busy      (rx_busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The receiver is described by the age (in ticks) since the start edge was seen:
  // age OS/2 is mid start bit, every OS ticks after that one more bit is sampled.
  logic          m_rxd1   = 1'b1;
  logic          m_rxd2   = 1'b1;
  logic          m_armed  = 1'b1;
  logic          m_active = 1'b0;
  int            m_age    = 0;
  logic [DB-1:0] m_bits   = '0;
  logic [DB-1:0] m_data   = '0;
  logic          m_valid  = 1'b0;
  logic          m_ferr   = 1'b0;
  logic          m_ovr    = 1'b0;

  always @(posedge clk) begin : model
    logic rs;
    logic was_valid;
    int   k;
    rs        = m_rxd2;
    m_rxd2    = m_rxd1;
    m_rxd1    = rx;
    was_valid = m_valid;
    m_ferr    = 1'b0;
    m_ovr     = 1'b0;
    if (rst) begin
      m_rxd1   = 1'b1;
      m_rxd2   = 1'b1;
      m_armed  = 1'b1;
      m_active = 1'b0;
      m_age    = 0;
      m_bits   = '0;
      m_data   = '0;
      m_valid  = 1'b0;
    end else begin
      if (was_valid && rx_ready) m_valid = 1'b0;
      if (baud_tick) begin
        if (!m_active) begin
          if (rs) m_armed = 1'b1;
          else if (m_armed) begin
            m_active = 1'b1;
            m_age    = 0;
          end
        end else begin
          m_age++;
          if (m_age == OS / 2) begin
            if (rs) m_active = 1'b0;
          end else if (m_age > OS / 2 && (m_age - OS / 2) % OS == 0) begin
            k = (m_age - OS / 2) / OS;
            if (k <= DB) begin
              m_bits[k-1] = rs;
            end else begin
              m_active = 1'b0;
              if (!rs) begin
                m_ferr  = 1'b1;
                m_armed = 1'b0;
              end else if (!was_valid || rx_ready) begin
                m_data  = m_bits;
                m_valid = 1'b1;
              end else begin
                m_ovr = 1'b1;
              end
            end
          end
        end
      end
    end
  end

  // ---------------- compare + event counters ----------------
  int            n_valid_cyc = 0;
  int            n_invalid   = 0;
  int            n_ferr      = 0;
  int            n_ovr       = 0;
  int            n_busy_rise = 0;
  logic          prev_busy   = 1'b0;
  logic [DB-1:0] last_data   = '0;

  always @(negedge clk) begin
    check("outs{busy,valid,ferr,ovr,data}",
          32'({rx_busy, rx_valid, rx_frame_err, rx_overrun, rx_data}),
          32'({m_active, m_valid, m_ferr, m_ovr, m_data}));
    if (rx_valid) begin
      n_valid_cyc++;
      last_data = rx_data;
    end else begin
      n_invalid++;
    end
    if (rx_frame_err) n_ferr++;
    if (rx_overrun) n_ovr++;
    if (rx_busy && !prev_busy) n_busy_rise++;
    prev_busy = rx_busy;
  end

  task automatic clear_mon();
    n_valid_cyc = 0;
    n_invalid   = 0;
    n_ferr      = 0;
    n_ovr       = 0;
    n_busy_rise = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin : tick_and_ready
    int ph;
    ph = 0;
    forever begin
      @(posedge clk);
      #1;
      ph        = (ph + 1) % 4;
      baud_tick = (ph == 0);
      case (ready_mode)
        1:       rx_ready = ($urandom_range(0, 3) == 0);
        2:       rx_ready = baud_tick && m_active && (m_age == STOP_AGE - 1);
        default: rx_ready = ready_fixed;
      endcase
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [DB-1:0] b, input logic stop_bit);
    rx = 1'b0;
    step(CLK_PER_BIT);
    for (int i = 0; i < DB; i++) begin
      rx = b[i];
      step(CLK_PER_BIT);
    end
    rx = stop_bit;
    step(CLK_PER_BIT);
    rx = 1'b1;
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    step(n * CLK_PER_BIT);
  endtask

  initial begin : main
    rst = 1'b1;
    step(5);
    rst = 1'b0;
    check("reset_outs", 32'({rx_busy, rx_valid, rx_frame_err, rx_overrun, rx_data}), 32'h0);
    idle_bits(2);

    // Good frame with the sink always ready.
    ready_fixed = 1'b1;
    clear_mon();
    send_frame(8'hA5, 1'b1);
    idle_bits(1);
    check("a5_data", 32'(last_data), 32'hA5);
    check("a5_valid_cycles", 32'(n_valid_cyc), 32'd1);
    check("a5_frame_err", 32'(n_ferr), 32'd0);
    check("a5_busy_after", 32'(rx_busy), 32'd0);

    // Start glitch: low for 4 ticks only.
    clear_mon();
    rx = 1'b0;
    step(16);
    idle_bits(2);
    check("glitch_started", 32'(n_busy_rise), 32'd1);
    check("glitch_valid", 32'(n_valid_cyc), 32'd0);
    check("glitch_ferr", 32'(n_ferr), 32'd0);
    check("glitch_ovr", 32'(n_ovr), 32'd0);

    // Framing error followed by a held-low break, then a good frame.
    clear_mon();
    send_frame(8'h3C, 1'b0);
    rx = 1'b0;
    step(3 * CLK_PER_BIT);
    idle_bits(2);
    send_frame(8'h5A, 1'b1);
    idle_bits(1);
    check("break_ferr_pulses", 32'(n_ferr), 32'd1);
    check("break_starts", 32'(n_busy_rise), 32'd2);
    check("break_5a_data", 32'(last_data), 32'h5A);
    check("break_5a_valid", 32'(n_valid_cyc), 32'd1);

    // Back-to-back frames into a full holding register.
    ready_fixed = 1'b0;
    clear_mon();
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    idle_bits(1);
    check("ovr_valid", 32'(rx_valid), 32'd1);
    check("ovr_data", 32'(rx_data), 32'h11);
    check("ovr_pulses", 32'(n_ovr), 32'd1);

    // Accept coincident with a new load.
    clear_mon();
    ready_mode = 2;
    send_frame(8'h22, 1'b1);
    idle_bits(1);
    ready_mode = 0;
    check("acc_load_data", 32'(rx_data), 32'h22);
    check("acc_load_valid", 32'(rx_valid), 32'd1);
    check("acc_load_never_empty", 32'(n_invalid), 32'd0);
    check("acc_load_ovr", 32'(n_ovr), 32'd0);

    // Reset in the middle of a frame.
    fork
      send_frame(8'hFF, 1'b1);
      begin
        step(5 * CLK_PER_BIT);
        rst = 1'b1;
        step(1);
        check("midreset_outs", 32'({rx_busy, rx_valid, rx_frame_err, rx_overrun, rx_data}), 32'h0);
        rst = 1'b0;
      end
    join
    idle_bits(1);
    ready_fixed = 1'b1;
    clear_mon();
    send_frame(8'h5A, 1'b1);
    idle_bits(1);
    check("post_reset_data", 32'(last_data), 32'h5A);
    check("post_reset_valid", 32'(n_valid_cyc), 32'd1);

    // Randomized traffic: bytes, stop errors, short glitches, gaps and sink stalls.
    ready_mode = 1;
    for (int i = 0; i < 40; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r == 0) begin
        rx = 1'b0;
        step($urandom_range(4, 24));
        rx = 1'b1;
      end else begin
        send_frame(DB'($urandom), r != 1);
      end
      rx = 1'b1;
      step($urandom_range(1, 3) * CLK_PER_BIT + $urandom_range(0, 20));
    end
    ready_mode = 0;
    idle_bits(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
